// File: rtl/rblwe_cmd_sequencer.sv
// rblwe_cmd_sequencer
//   Host-side initiator for the RBLWE accelerator. Queues host instructions
//   in a small FIFO, issues them one at a time with a single-cycle start
//   pulse, holds operands and H stable while the accelerator works, and
//   returns the captured W word through a valid/ready response port.
//   Also owns the 36-bit H register (host loads, SAMPLE results overwrite).
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   i_cmd_valid / o_cmd_ready  host command handshake (ready = FIFO not full)
//   i_cmd_opcode/d/g/b         command opcode and operands
//   i_h_load, i_h_load_data    one-cycle H load strobe and value
//   o_h_reg                    current H
//   o_acc_start                one-cycle start pulse to the accelerator
//   o_acc_opcode/d/g/b/h       command in flight, held from issue onwards
//   i_acc_w/valid/done         accelerator result, valid, completion
//   o_rsp_valid / i_rsp_ready  response handshake
//   o_rsp_opcode/w/err         response payload (w = 0 when err)
//   o_busy                     FSM active or commands still queued
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the FIFO head
// ISSUE  | start pulse cycle, operands presented to accelerator
// WAIT   | waiting for acc_done, timeout down-counter running
// ERR    | illegal opcode, build error response without issuing
// RESP   | response held until the host accepts it
module rblwe_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [4:0]  i_cmd_opcode,
  input  logic [31:0] i_cmd_d,
  input  logic [31:0] i_cmd_g,
  input  logic [31:0] i_cmd_b,
  input  logic        i_h_load,
  input  logic [35:0] i_h_load_data,
  output logic [35:0] o_h_reg,
  output logic        o_acc_start,
  output logic [4:0]  o_acc_opcode,
  output logic [31:0] o_acc_d,
  output logic [31:0] o_acc_g,
  output logic [31:0] o_acc_b,
  output logic [35:0] o_acc_h,
  input  logic [35:0] i_acc_w,
  input  logic        i_acc_valid,
  input  logic        i_acc_done,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [4:0]  o_rsp_opcode,
  output logic [35:0] o_rsp_w,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW:0]   PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    OP_SAMPLE = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ERR   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Command FIFO storage (no reset needed, guarded by pointers)
  logic [4:0]  r_fifo_op [FIFO_DEPTH];
  logic [31:0] r_fifo_d  [FIFO_DEPTH];
  logic [31:0] r_fifo_g  [FIFO_DEPTH];
  logic [31:0] r_fifo_b  [FIFO_DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_captured;
  logic [35:0]   r_w_cap;
  logic [35:0]   r_h_reg;
  logic          r_acc_start;
  logic [4:0]    r_acc_opcode;
  logic [31:0]   r_acc_d;
  logic [31:0]   r_acc_g;
  logic [31:0]   r_acc_b;
  logic [35:0]   r_acc_h;
  logic          r_rsp_valid;
  logic [4:0]    r_rsp_opcode;
  logic [35:0]   r_rsp_w;
  logic          r_rsp_err;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_head_legal;
  logic [4:0]  w_head_op;
  logic [31:0] w_head_d;
  logic [31:0] w_head_g;
  logic [31:0] w_head_b;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign w_head_op = r_fifo_op[r_rd_ptr[PW-1:0]];
  assign w_head_d  = r_fifo_d[r_rd_ptr[PW-1:0]];
  assign w_head_g  = r_fifo_g[r_rd_ptr[PW-1:0]];
  assign w_head_b  = r_fifo_b[r_rd_ptr[PW-1:0]];

  always_comb begin
    w_head_legal = 1'b0;
    case (w_head_op)
      5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00110: w_head_legal = 1'b1;
      default:                                          w_head_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr[PW-1:0]] <= i_cmd_opcode;
      r_fifo_d[r_wr_ptr[PW-1:0]]  <= i_cmd_d;
      r_fifo_g[r_wr_ptr[PW-1:0]]  <= i_cmd_g;
      r_fifo_b[r_wr_ptr[PW-1:0]]  <= i_cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_captured   <= 1'b0;
      r_w_cap      <= '0;
      r_h_reg      <= '0;
      r_acc_start  <= 1'b0;
      r_acc_opcode <= '0;
      r_acc_d      <= '0;
      r_acc_g      <= '0;
      r_acc_b      <= '0;
      r_acc_h      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_opcode <= '0;
      r_rsp_w      <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_acc_start <= 1'b0;

      // A SAMPLE completion takes priority over a coincident host load
      if (r_state == S_WAIT && i_acc_done && r_acc_opcode == OP_SAMPLE)
        r_h_reg <= i_acc_w;
      else if (i_h_load)
        r_h_reg <= i_h_load_data;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rsp_opcode <= w_head_op;
            if (w_head_legal) begin
              r_acc_start  <= 1'b1;
              r_acc_opcode <= w_head_op;
              r_acc_d      <= w_head_d;
              r_acc_g      <= w_head_g;
              r_acc_b      <= w_head_b;
              r_acc_h      <= r_h_reg;
              r_state      <= S_ISSUE;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_ISSUE: begin
          r_timer    <= TMR_LOAD;
          r_captured <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (i_acc_done) begin
            r_rsp_w     <= r_captured ? r_w_cap : i_acc_w;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_timer == '0) begin
            r_rsp_w     <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer - TMR_ONE;
            // Only the first valid beat is kept; later beats are ignored
            if (i_acc_valid && !r_captured) begin
              r_captured <= 1'b1;
              r_w_cap    <= i_acc_w;
            end
          end
        end
        S_ERR: begin
          r_rsp_w     <= '0;
          r_rsp_err   <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = !w_full;
  assign o_h_reg      = r_h_reg;
  assign o_acc_start  = r_acc_start;
  assign o_acc_opcode = r_acc_opcode;
  assign o_acc_d      = r_acc_d;
  assign o_acc_g      = r_acc_g;
  assign o_acc_b      = r_acc_b;
  assign o_acc_h      = r_acc_h;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_opcode = r_rsp_opcode;
  assign o_rsp_w      = r_rsp_w;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;

endmodule
